// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: 8-digit seven-segment scan controller with a double-buffered
// display word, a programmable on-time, a dead-time blanking gap and a debug
// override source.
// Ports: clk, rst_ni (async, active-low); bus we_i/re_i/addr_i/wdata_i/rdata_o
// (0 DATA, 1 MASK, 2 CTRL, 3 ACTIVE read-only); dbg_valid_i/dbg_data_i debug
// word; anode_o (active-low), nibble_o, digit_idx_o, frame_done_o.
// Optional macro SSD_LEADING_ZERO_BLANK_EN adds CTRL[2] leading-zero blanking.
module ssd_scan_ctrl #(
    parameter int DW           = 32,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [1:0]    addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    input  logic          dbg_valid_i,
    input  logic [DW-1:0] dbg_data_i,
    output logic [7:0]    anode_o,
    output logic [3:0]    nibble_o,
    output logic [2:0]    digit_idx_o,
    output logic          frame_done_o
);

    localparam int CMAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST =
        CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

`ifdef SSD_LEADING_ZERO_BLANK_EN
    localparam int CTW = 3;
`else
    localparam int CTW = 2;
`endif

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [DW-1:0]  data_q, data_d;
    logic [DW-1:0]  active_q, active_d;
    logic [7:0]     mask_q, mask_d;
    logic [CTW-1:0] ctrl_q, ctrl_d;
    logic [0:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     anode_q, anode_d;
    logic [3:0]     nibble_q, nibble_d;
    logic           frame_done_q, frame_done_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic [DW-1:0]  sel;
    logic [7:0]     eff_mask;

    always_comb begin
        data_d       = data_q;
        mask_d       = mask_q;
        ctrl_d       = ctrl_q;
        active_d     = active_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rdata_d      = rdata_q;
        frame_done_d = 1'b0;
        eff_mask     = mask_q;
        anode_d      = 8'hFF;

        sel = (ctrl_q[1] && dbg_valid_i) ? dbg_data_i : data_q;

        if (we_i) begin
            case (addr_i)
                2'd0:    data_d = wdata_i;
                2'd1:    mask_d = wdata_i[7:0];
                2'd2:    ctrl_d = wdata_i[CTW-1:0];
                default: ;
            endcase
        end

        // Reads see the register contents before any same-cycle write.
        if (re_i) begin
            case (addr_i)
                2'd0:    rdata_d = data_q;
                2'd1:    rdata_d = {{(DW-8){1'b0}}, mask_q};
                2'd2:    rdata_d = {{(DW-CTW){1'b0}}, ctrl_q};
                default: rdata_d = active_q;
            endcase
        end

        if (!ctrl_q[0]) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            idx_d    = 3'd0;
            active_d = sel;
        end else if (state_q == ST_BLANK) begin
            if (BLANK_CYCLES == 0 || cnt_q == BLK_LAST) begin
                state_d = ST_ON;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            if (cnt_q == ON_LAST) begin
                cnt_d   = '0;
                idx_d   = idx_q + 3'd1;
                state_d = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
                // Frame boundary: latch the next word from the old DATA.
                if (idx_q == 3'd7) begin
                    active_d     = sel;
                    frame_done_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (ctrl_q[2]) begin
            for (int i = 1; i < 8; i++) begin
                if ((active_d >> (4 * i)) == '0) eff_mask[i] = 1'b0;
            end
        end
`endif

        // Outputs are computed from next state so they register together.
        if (state_d == ST_ON && eff_mask[idx_d]) anode_d[idx_d] = 1'b0;
        nibble_d = active_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q       <= '0;
            active_q     <= '0;
            mask_q       <= 8'hFF;
            ctrl_q       <= '0;
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            anode_q      <= 8'hFF;
            nibble_q     <= 4'd0;
            frame_done_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            data_q       <= data_d;
            active_q     <= active_d;
            mask_q       <= mask_d;
            ctrl_q       <= ctrl_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            nibble_q     <= nibble_d;
            frame_done_q <= frame_done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign anode_o      = anode_q;
    assign nibble_o     = nibble_q;
    assign digit_idx_o  = idx_q;
    assign frame_done_o = frame_done_q;
    assign rdata_o      = rdata_q;

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Memory-mapped scan controller that sequences the 8-digit seven-segment display of the RISC-V core's board. It multiplexes digits with a programmable on-time and a dead-time blanking gap. It double-buffers the displayed word so updates never tear mid-frame, and arbitrates between core bus writes and a debug override source. Outputs are the active-low anode vector plus the 4-bit hex nibble that feeds the downstream hex-to-segment decoder.

Parameters:
DW, 32, data width of the display word and bus data (8 nibbles).
CLK_DIV, 100000, clk cycles each digit is lit (ON slot); must be >= 1.
BLANK_CYCLES, 1000, clk cycles all anodes are off between digits; 0 means no gap.

Ports:
clk  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
we_i  in  1  bus write strobe
re_i  in  1  bus read strobe
addr_i  in  2  register select: 0 DATA, 1 MASK, 2 CTRL, 3 ACTIVE (read-only)
wdata_i  in  DW  bus write data
rdata_o  out  DW  bus read data, registered
dbg_valid_i  in  1  debug source requests the display
dbg_data_i  in  DW  debug display word
anode_o  out  8  digit enables, active-low
nibble_o  out  4  hex value of the lit digit
digit_idx_o  out  3  current digit index
frame_done_o  out  1  one-cycle pulse at frame boundary

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_ni. Assertion takes effect immediately, with no clock edge.
- Reset values: DATA=0, ACTIVE=0, MASK=8'hFF, CTRL=0, state=BLANK, counter=0, digit_idx_o=0, anode_o=8'hFF, nibble_o=0, frame_done_o=0, rdata_o=0.
- CTRL bits: [0] enable, [1] dbg_en, [2] lz_blank (see optional feature). Other bits read 0.
- Writes: when we_i is high, addr_i selects the register, which updates on the next edge. Writes to addr 3 are ignored. MASK takes wdata_i[7:0].
- Reads: when re_i is high, rdata_o is valid the next cycle with zero-extended contents. When re_i is low, rdata_o holds its value.
- Simultaneous we_i/re_i to the same address: the read returns the pre-write value.
- Source select (sel): if CTRL.dbg_en && dbg_valid_i, then dbg_data_i; else DATA.
- enable=0:
  - FSM forced to BLANK, counter=0, idx=0, anode_o=8'hFF.
  - ACTIVE <= sel every cycle.
- FSM (enable=1), two states:
  - BLANK: anode_o=8'hFF for exactly BLANK_CYCLES cycles, then go to ON.
  - ON: lasts exactly CLK_DIV cycles.
    - anode_o has bit idx cleared if MASK[idx]=1; otherwise anode_o=8'hFF.
    - nibble_o = ACTIVE[4*idx +: 4], valid regardless of mask.
    - At the end of ON: idx <= idx+1 mod 8, then go to BLANK, or to ON directly if BLANK_CYCLES=0.
- Frame boundary is the ON to next-slot transition where idx wraps 7 to 0. On that edge, ACTIVE <= sel and frame_done_o pulses high for one cycle.
- Frame period is 8*(CLK_DIV+BLANK_CYCLES) cycles. The first ON after enable rises is digit 0, following one BLANK.
- A DATA write landing on the frame-boundary edge is not captured. ACTIVE takes the old DATA, and the new value appears the following frame.
- Clearing enable mid-frame: next cycle goes to BLANK/idx 0. No frame_done pulse.
- dbg_valid_i dropping mid-frame has no effect until the next boundary.
- anode_o, nibble_o and digit_idx_o are registered and change together.
- Counter width is $clog2(max(CLK_DIV,BLANK_CYCLES)+1).

Optional Feature:
SSD_LEADING_ZERO_BLANK_EN
- Defined: CTRL[2] is writable. When it is set, any digit idx>0 whose nibble and all higher nibbles of ACTIVE are zero is treated as MASK[idx]=0, so its anode stays high. Digit 0 always follows MASK.
- Undefined: CTRL[2] reads 0, writes to it are ignored, and no extra logic is generated.

Test Plan:
All tests use CLK_DIV=4, BLANK_CYCLES=2.
1. rst_ni low for 3 cycles, then released with CTRL=0 -> anode_o=8'hFF, nibble_o=0 and rdata_o=0 throughout; read addr1 -> 0x000000FF.
2. Write DATA=0x87654321, then CTRL=1 -> 2 cycles 8'hFF, then 4 cycles FE/nibble 1, 2 cycles FF, 4 cycles FD/nibble 2 ... 4 cycles 7F/nibble 8; frame_done_o pulses once 8*6 cycles after the first BLANK.
3. MASK=0x0F, DATA=0x87654321, enable -> digits 4-7 ON slots show anode_o=8'hFF with nibble_o still 5,6,7,8.
4. Mid-frame write DATA=0xDEADBEEF -> remaining digits of the current frame still show 0x87654321; the next frame shows F,E,E,B,D,A,E,D; read addr3 before the boundary returns 0x87654321.
5. CTRL=3, dbg_valid_i=1, dbg_data_i=0x12345678 -> from the next frame, digits show 8,7,...,1; addr3 reads 0x12345678. Dropping dbg_valid_i mid-frame -> the following frame reverts to DATA.
6. rst_ni pulled low mid-ON slot between clock edges -> anode_o=8'hFF and frame_done_o=0 immediately; after release, CTRL=0 and the display stays dark.
7. With SSD_LEADING_ZERO_BLANK_EN defined: CTRL=5, DATA=0x00000A05 -> digits 0-2 lit (5,0,A), digits 3-7 anode high.
